// File: rtl/regfile_wb_unit_pkg.sv
// Shared types and constants for the writeback register file and its load scoreboard.
package regfile_wb_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [1:0] sb_cnt_t;
  localparam sb_cnt_t SB_MAX = 2'd3;

  typedef enum logic {
    WB_SEL_ALU,
    WB_SEL_MEM
  } wb_sel_e;

endpackage

// File: rtl/regfile_wb_unit_load_scoreboard.sv
// Per-register count of outstanding loads; flags decode reads that would consume a pending load.
module regfile_wb_unit_load_scoreboard
  import regfile_wb_unit_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  wb_load,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  load_hazard
);

  sb_cnt_t cnt_q [NUM_REGS];
  sb_cnt_t cnt_d [NUM_REGS];
  logic    inc;
  logic    dec;

  assign inc = issue_load && (issue_rd != '0);
  assign dec = wb_load && (wb_rd != '0);

  // A matching inc and dec cancel; both directions saturate so stale loads after a flush stay at 0.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc && (issue_rd == REG_ADDR_W'(i)) && !(dec && (wb_rd == REG_ADDR_W'(i)))) begin
        if (cnt_q[i] != SB_MAX) cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec && (wb_rd == REG_ADDR_W'(i)) && !(inc && (issue_rd == REG_ADDR_W'(i)))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign load_hazard = ((rs1 != '0) && (cnt_q[rs1] != '0)) ||
                       ((rs2 != '0) && (cnt_q[rs2] != '0));

endmodule

// File: rtl/regfile_wb_unit.sv
// Writeback commit into a 32-entry register file with same-cycle read bypass and load-use hazard flag.
// Optional retire counter output enabled by defining REGFILE_WB_RETIRE_COUNT_EN.
module regfile_wb_unit
  import regfile_wb_unit_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_regWrite,
  input  logic                  wb_memRead,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_memory_data,
  input  logic [DATA_WIDTH-1:0] wb_ALU_result,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  load_hazard,
  output logic                  wb_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_WIDTH-1:0] wb_write_data
`ifdef REGFILE_WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  wb_sel_e               wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  we;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  unused_params;

  assign unused_params = (CORE != 0) ^ (ADDRESS_BITS != 0);

  always_comb begin
    wr_sel  = wb_memRead ? WB_SEL_MEM : WB_SEL_ALU;
    wr_data = (wr_sel == WB_SEL_MEM) ? wb_memory_data : wb_ALU_result;
    we      = wb_regWrite && (wb_rd != '0);
  end

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wb_rd] = wr_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // The committing value is bypassed so decode never sees the stale entry in the commit cycle.
  always_comb begin
    rs1_data = regs_q[rs1];
    if (rs1 == '0)                 rs1_data = '0;
    else if (we && (rs1 == wb_rd)) rs1_data = wr_data;
    rs2_data = regs_q[rs2];
    if (rs2 == '0)                 rs2_data = '0;
    else if (we && (rs2 == wb_rd)) rs2_data = wr_data;
  end

  assign wb_write      = we;
  assign wb_write_reg  = wb_rd;
  assign wb_write_data = wr_data;

  regfile_wb_unit_load_scoreboard u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_load  (issue_load),
    .issue_rd    (issue_rd),
    .wb_load     (wb_regWrite && wb_memRead),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .load_hazard (load_hazard)
  );

`ifdef REGFILE_WB_RETIRE_COUNT_EN
  logic [31:0] retire_q;
  logic [31:0] retire_d;

  // Counts every retiring writer, including those targeting x0.
  always_comb begin
    retire_d = retire_q;
    if (wb_regWrite) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Scoreboard bench for regfile_wb_unit: stimulus queues expectations, a monitor pops and compares.
// Retire counter checks are built only when REGFILE_WB_RETIRE_COUNT_EN is defined.
module tb_regfile_wb_unit;

  logic        clock;
  logic        reset;
  logic        wb_regWrite;
  logic        wb_memRead;
  logic [4:0]  wb_rd;
  logic [31:0] wb_memory_data;
  logic [31:0] wb_ALU_result;
  logic        issue_load;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        load_hazard;
  logic        wb_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
`ifdef REGFILE_WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  typedef struct {
    string       name;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        hazard;
    logic        wr;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  regfile_wb_unit dut (
    .clock          (clock),
    .reset          (reset),
    .wb_regWrite    (wb_regWrite),
    .wb_memRead     (wb_memRead),
    .wb_rd          (wb_rd),
    .wb_memory_data (wb_memory_data),
    .wb_ALU_result  (wb_ALU_result),
    .issue_load     (issue_load),
    .issue_rd       (issue_rd),
    .flush          (flush),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .load_hazard    (load_hazard),
    .wb_write       (wb_write),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data)
`ifdef REGFILE_WB_RETIRE_COUNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the hand-computed response.
  task automatic apply_vector(input string name, input logic rst_v,
                              input logic reg_write, input logic mem_read, input logic [4:0] rd,
                              input logic [31:0] mem, input logic [31:0] alu,
                              input logic il, input logic [4:0] ird, input logic fl,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] e1, input logic [31:0] e2, input logic eh);
    exp_t e;
    @(negedge clock);
    reset          = rst_v;
    wb_regWrite    = reg_write;
    wb_memRead     = mem_read;
    wb_rd          = rd;
    wb_memory_data = mem;
    wb_ALU_result  = alu;
    issue_load     = il;
    issue_rd       = ird;
    flush          = fl;
    rs1            = r1;
    rs2            = r2;
    e.name     = name;
    e.rs1_data = e1;
    e.rs2_data = e2;
    e.hazard   = eh;
    e.wr       = reg_write && (rd != 5'd0);
    e.wr_reg   = rd;
    e.wr_data  = mem_read ? mem : alu;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2, input logic eh);
    apply_vector(name, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, r1, r2, e1, e2, eh);
  endtask

  // Monitor: compares every queued expectation once the driven inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "rs1_data",      rs1_data,             e.rs1_data);
        check(e.name, "rs2_data",      rs2_data,             e.rs2_data);
        check(e.name, "load_hazard",   {31'd0, load_hazard}, {31'd0, e.hazard});
        check(e.name, "wb_write",      {31'd0, wb_write},    {31'd0, e.wr});
        check(e.name, "wb_write_reg",  {27'd0, wb_write_reg},{27'd0, e.wr_reg});
        check(e.name, "wb_write_data", wb_write_data,        e.wr_data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; wb_regWrite = 1'b0; wb_memRead = 1'b0; wb_rd = '0;
    wb_memory_data = '0; wb_ALU_result = '0; issue_load = 1'b0; issue_rd = '0;
    flush = 1'b0; rs1 = '0; rs2 = '0;

    //           name            rst  rw   mr   rd     mem            alu            il   ird    fl   rs1    rs2    exp1           exp2           haz
    apply_vector("in_reset",     1'b0,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b0,5'd0,  1'b0,5'd5,  5'd31, 32'h0,         32'h0,         1'b0);
    idle        ("reset_read",                                                                          5'd5,  5'd31, 32'h0,         32'h0,         1'b0);
    apply_vector("bypass",       1'b1,1'b1,1'b0,5'd7,  32'h11111111,  32'hDEADBEEF,  1'b0,5'd0,  1'b0,5'd7,  5'd0,  32'hDEADBEEF,  32'h0,         1'b0);
    idle        ("storage",                                                                             5'd7,  5'd0,  32'hDEADBEEF,  32'h0,         1'b0);
    apply_vector("x0_write",     1'b1,1'b1,1'b0,5'd0,  32'h0,         32'h00001234,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  32'h0,         32'h0,         1'b0);
    idle        ("x0_read",                                                                             5'd0,  5'd7,  32'h0,         32'hDEADBEEF,  1'b0);
    apply_vector("mem_sel",      1'b1,1'b1,1'b1,5'd3,  32'hCAFEF00D,  32'h00000055,  1'b0,5'd0,  1'b0,5'd3,  5'd7,  32'hCAFEF00D,  32'hDEADBEEF,  1'b0);
    apply_vector("issue9_a",     1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd9,  1'b0,5'd3,  5'd9,  32'hCAFEF00D,  32'h0,         1'b0);
    apply_vector("issue9_b",     1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd9,  1'b0,5'd3,  5'd9,  32'hCAFEF00D,  32'h0,         1'b1);
    idle        ("haz9_cnt2",                                                                           5'd0,  5'd9,  32'h0,         32'h0,         1'b1);
    apply_vector("wb9_first",    1'b1,1'b1,1'b1,5'd9,  32'hA5A5A5A5,  32'h0,         1'b0,5'd0,  1'b0,5'd0,  5'd9,  32'h0,         32'hA5A5A5A5,  1'b1);
    idle        ("haz9_cnt1",                                                                           5'd0,  5'd9,  32'h0,         32'hA5A5A5A5,  1'b1);
    apply_vector("wb9_second",   1'b1,1'b1,1'b1,5'd9,  32'h5A5A0001,  32'h0,         1'b0,5'd0,  1'b0,5'd0,  5'd9,  32'h0,         32'h5A5A0001,  1'b1);
    idle        ("haz9_clear",                                                                          5'd0,  5'd9,  32'h0,         32'h5A5A0001,  1'b0);
    apply_vector("sat_inc1",     1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd4,  1'b0,5'd4,  5'd0,  32'h0,         32'h0,         1'b0);
    for (int i = 0; i < 3; i++)
      apply_vector("sat_incN",   1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd4,  1'b0,5'd4,  5'd0,  32'h0,         32'h0,         1'b1);
    idle        ("sat_hold",                                                                            5'd4,  5'd0,  32'h0,         32'h0,         1'b1);
    apply_vector("sat_dec1",     1'b1,1'b1,1'b1,5'd4,  32'h44440001,  32'h0,         1'b0,5'd0,  1'b0,5'd4,  5'd0,  32'h44440001,  32'h0,         1'b1);
    apply_vector("sat_dec2",     1'b1,1'b1,1'b1,5'd4,  32'h44440002,  32'h0,         1'b0,5'd0,  1'b0,5'd4,  5'd0,  32'h44440002,  32'h0,         1'b1);
    apply_vector("inc_dec_same", 1'b1,1'b1,1'b1,5'd4,  32'h44440003,  32'h0,         1'b1,5'd4,  1'b0,5'd4,  5'd0,  32'h44440003,  32'h0,         1'b1);
    idle        ("cnt4_still1",                                                                         5'd4,  5'd0,  32'h44440003,  32'h0,         1'b1);
    apply_vector("flush",        1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd4,  1'b1,5'd4,  5'd0,  32'h44440003,  32'h0,         1'b1);
    idle        ("post_flush",                                                                          5'd4,  5'd0,  32'h44440003,  32'h0,         1'b0);
    apply_vector("stale_wb4",    1'b1,1'b1,1'b1,5'd4,  32'h44440004,  32'h0,         1'b0,5'd0,  1'b0,5'd4,  5'd0,  32'h44440004,  32'h0,         1'b0);
    idle        ("no_underflow",                                                                        5'd4,  5'd0,  32'h44440004,  32'h0,         1'b0);
    apply_vector("pre_reset",    1'b1,1'b0,1'b0,5'd0,  32'h0,         32'h0,         1'b1,5'd4,  1'b0,5'd7,  5'd4,  32'hDEADBEEF,  32'h44440004,  1'b0);
    apply_vector("reset_mid",    1'b0,1'b1,1'b0,5'd5,  32'h0,         32'h00000055,  1'b0,5'd0,  1'b0,5'd7,  5'd4,  32'h0,         32'h0,         1'b0);
    idle        ("post_reset_a",                                                                        5'd5,  5'd4,  32'h0,         32'h0,         1'b0);
    idle        ("post_reset_b",                                                                        5'd7,  5'd9,  32'h0,         32'h0,         1'b0);

    @(negedge clock);
    #4;
    check("drain", "queue_size", exp_q.size(), 32'd0);

`ifdef REGFILE_WB_RETIRE_COUNT_EN
    force dut.retire_q = 32'hFFFFFFFE;
    #1;
    release dut.retire_q;
    apply_vector("ret_commit1",  1'b1,1'b1,1'b0,5'd6,  32'h0,         32'h00000066,  1'b0,5'd0,  1'b0,5'd6,  5'd0,  32'h00000066,  32'h0,         1'b0);
    apply_vector("ret_commit_x0",1'b1,1'b1,1'b0,5'd0,  32'h0,         32'h00000077,  1'b0,5'd0,  1'b0,5'd6,  5'd0,  32'h00000066,  32'h0,         1'b0);
    idle        ("ret_idle",                                                                            5'd6,  5'd0,  32'h00000066,  32'h0,         1'b0);
    #4;
    check("ret_wrap", "retire_count", retire_count, 32'h0);
    apply_vector("ret_commit3",  1'b1,1'b1,1'b0,5'd6,  32'h0,         32'h00000088,  1'b0,5'd0,  1'b0,5'd0,  5'd0,  32'h0,         32'h0,         1'b0);
    idle        ("ret_idle2",                                                                           5'd0,  5'd0,  32'h0,         32'h0,         1'b0);
    #4;
    check("ret_one", "retire_count", retire_count, 32'h1);
    reset = 1'b0;
    #1;
    check("ret_reset", "retire_count", retire_count, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #4;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
